// File: rtl/grid_io_pkg.sv
// grid_io_pkg: shared per-channel config layout and constants for grid_io_multi
package grid_io_pkg;
   localparam int CFG_BITS    = 3;
   localparam int CFG_OUT_EN  = 0;
   localparam int CFG_REG_OUT = 1;
   localparam int CFG_REG_IN  = 2;
   typedef struct packed {
      logic reg_in;
      logic reg_out;
      logic out_en;
   } io_cfg_t;
endpackage

// File: rtl/grid_io_channel.sv
// grid_io_channel: one pad's output mux, input path, isolation gating; GRID_IO_INPUT_SYNC_EN adds a 2-flop input synchroniser
module grid_io_channel
   import grid_io_pkg::*;
(
   input  logic    prog_clk_i,
   input  logic    prog_reset_n_i,
   input  logic    iso_n_i,
   input  io_cfg_t cfg_i,
   input  logic    pad_in_i,
   output logic    pad_out_o,
   output logic    pad_dir_o,
   input  logic    fab_out_i,
   output logic    fab_in_o
);
   logic clr;
   logic in_s;
   logic out_q, out_d;
   logic in_q, in_d;
   assign clr = ~iso_n_i;
`ifdef GRID_IO_INPUT_SYNC_EN
   logic [1:0] sync_q, sync_d;
   // two-stage synchroniser, flushed while isolated
   always_comb sync_d = clr ? 2'b00 : {sync_q[0], pad_in_i};
   // synchroniser state with reset
   always_ff @(posedge prog_clk_i)
      if (!prog_reset_n_i) sync_q <= '0;
      else                 sync_q <= sync_d;
   assign in_s = sync_q[1];
`else
   assign in_s = pad_in_i;
`endif
   // registered data paths restart from zero after isolation
   always_comb begin
      out_d = clr ? 1'b0 : fab_out_i;
      in_d  = clr ? 1'b0 : in_s;
   end
   // data registers with reset
   always_ff @(posedge prog_clk_i)
      if (!prog_reset_n_i) begin
         out_q <= 1'b0;
         in_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         in_q  <= in_d;
      end
   assign pad_dir_o = ~(iso_n_i & cfg_i.out_en);
   assign pad_out_o = iso_n_i & cfg_i.out_en & (cfg_i.reg_out ? out_q : fab_out_i);
   assign fab_in_o  = iso_n_i & ~cfg_i.out_en & (cfg_i.reg_in ? in_q : in_s);
endmodule

// File: rtl/grid_io_multi.sv
// grid_io_multi: NUM_IO-pad I/O tile with double-buffered config chain; GRID_IO_INPUT_SYNC_EN enables input synchronisers
module grid_io_multi
   import grid_io_pkg::*;
#(
   parameter int NUM_IO = 4
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              IO_ISOL_N,
   input  logic              ccff_en,
   input  logic              ccff_head,
   output logic              ccff_tail,
   input  logic              cfg_commit,
   output logic              cfg_loaded,
   input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
   output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
   input  logic [NUM_IO-1:0] io_outpad,
   output logic [NUM_IO-1:0] io_inpad
);
   localparam int W = NUM_IO * CFG_BITS;
   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] active_q, active_d;
   logic         loaded_q, loaded_d;
   // commit captures the pre-shift shadow even when a shift happens in the same cycle
   always_comb begin
      shadow_d = ccff_en ? {shadow_q[W-2:0], ccff_head} : shadow_q;
      active_d = cfg_commit ? shadow_q : active_q;
      loaded_d = loaded_q | cfg_commit;
   end
   // config chain state with reset
   always_ff @(posedge prog_clk)
      if (!prog_reset_n) begin
         shadow_q <= '0;
         active_q <= '0;
         loaded_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         loaded_q <= loaded_d;
      end
   assign ccff_tail  = shadow_q[W-1];
   assign cfg_loaded = loaded_q;
   for (genvar g = 0; g < NUM_IO; g++) begin : g_ch
      io_cfg_t cfg;
      assign cfg = io_cfg_t'(active_q[g*CFG_BITS +: CFG_BITS]);
      grid_io_channel u_ch (
         .prog_clk_i     (prog_clk),
         .prog_reset_n_i (prog_reset_n),
         .iso_n_i        (IO_ISOL_N),
         .cfg_i          (cfg),
         .pad_in_i       (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[g]),
         .pad_out_o      (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[g]),
         .pad_dir_o      (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[g]),
         .fab_out_i      (io_outpad[g]),
         .fab_in_o       (io_inpad[g])
      );
   end
endmodule
